nvm_flash_seq: RTL and testbench

- Parametrised flash operation sequencer for the NVM controller.
- Accepts one command at a time (READ, PROGRAM, ERASE) from the AHB-side front end over a valid/ready handshake.
- Drives the raw flash array pins with programmable setup, pulse and hold timing.
- Returns read data or an error on a response handshake. Generalises the fixed word, block and page widths to parameters and adds a locked-block region.

---
 rtl/nvm_pkg.sv | 46 ++++
 rtl/nvm_pulse_timer.sv | 29 ++
 rtl/nvm_flash_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_nvm_flash_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvm_pkg.sv
// nvm_pkg: shared types and default timing for the NVM flash sequencer.
// Macro NVM_PROG_VERIFY_EN adds the VERIFY state to seq_state_t.
package nvm_pkg;

  // Default geometry and timing; the sequencer parameters default to these
  localparam int DEF_WORD_W      = 32;
  localparam int DEF_BLOCK_W     = 10;
  localparam int DEF_PAGE_W      = 6;
  localparam int DEF_MODE_W      = 4;
  localparam int DEF_T_READ      = 2;
  localparam int DEF_T_PROG      = 8;
  localparam int DEF_T_ERASE     = 64;
  localparam int DEF_LOCK_BLOCKS = 1;
  localparam int DEF_MAX_RETRY   = 3;

  typedef logic [DEF_WORD_W-1:0]  word_t;
  typedef logic [DEF_BLOCK_W-1:0] block_t;
  typedef logic [DEF_PAGE_W-1:0]  page_t;

  // Array address as presented on the flash pins: block in the upper bits
  typedef struct packed {
    block_t block;
    page_t  page;
  } flash_addr_t;

  // Command encodings; any other value of the mode field is illegal
  typedef enum logic [DEF_MODE_W-1:0] {
    MODE_NOP     = 4'd0,
    MODE_READ    = 4'd1,
    MODE_PROGRAM = 4'd2,
    MODE_ERASE   = 4'd3
  } flash_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_PULSE  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_RESP   = 3'd5
`ifdef NVM_PROG_VERIFY_EN
    , ST_VERIFY = 3'd6
`endif
  } seq_state_t;

endpackage

// File: rtl/nvm_pulse_timer.sv
// nvm_pulse_timer: loadable down-counter shared by every pulse width.
// zero is high whenever the count has reached 0; en stops decrementing at 0.
module nvm_pulse_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  // Load has priority; otherwise count down while enabled and not yet at 0
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/nvm_flash_seq.sv
// nvm_flash_seq: one-command-at-a-time flash operation sequencer.
// IDLE -> CHECK -> SETUP -> PULSE -> HOLD -> RESP; errors skip to RESP.
// Optional macro NVM_PROG_VERIFY_EN: read-back verify after PROGRAM with
// up to MAX_RETRY re-program attempts.
module nvm_flash_seq
  import nvm_pkg::*;
#(
  parameter int WORD_W       = DEF_WORD_W,
  parameter int BLOCK_W      = DEF_BLOCK_W,
  parameter int PAGE_W       = DEF_PAGE_W,
  parameter int FLASH_MODE_W = DEF_MODE_W,
  parameter int T_READ       = DEF_T_READ,
  parameter int T_PROG       = DEF_T_PROG,
  parameter int T_ERASE      = DEF_T_ERASE,
  parameter int LOCK_BLOCKS  = DEF_LOCK_BLOCKS,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [FLASH_MODE_W-1:0]   cmd_mode,
  input  logic [BLOCK_W-1:0]        cmd_block,
  input  logic [PAGE_W-1:0]         cmd_page,
  input  logic [WORD_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WORD_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [BLOCK_W+PAGE_W-1:0] flash_addr,
  output logic [WORD_W-1:0]         flash_wdata,
  input  logic [WORD_W-1:0]         flash_rdata,
  output logic                      flash_re,
  output logic                      flash_we,
  output logic                      flash_erase,
  output logic                      busy
);

  localparam int CNT_W = $clog2(T_ERASE + 1);
  localparam logic [CNT_W-1:0] LD_READ  = CNT_W'(T_READ - 1);
  localparam logic [CNT_W-1:0] LD_PROG  = CNT_W'(T_PROG - 1);
  localparam logic [CNT_W-1:0] LD_ERASE = CNT_W'(T_ERASE - 1);

  seq_state_t               state_reg, state_next;
  logic [FLASH_MODE_W-1:0]  mode_reg;
  logic [BLOCK_W-1:0]       block_reg;
  logic [PAGE_W-1:0]        page_reg;
  logic [WORD_W-1:0]        wdata_reg;
  logic [WORD_W-1:0]        rdata_reg, rdata_next;
  logic                     err_reg, err_next;

  logic             tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  logic cmd_accept;
  logic is_nop, is_read, is_prog, is_erase, is_illegal, is_locked;

`ifdef NVM_PROG_VERIFY_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  logic [RETRY_W-1:0] retry_reg, retry_next;
`else
  localparam int unused_max_retry = MAX_RETRY;
`endif

  assign cmd_accept = cmd_valid && (state_reg == ST_IDLE);

  // Decode of the latched command; block lock only matters for writes
  assign is_nop     = (mode_reg == FLASH_MODE_W'(MODE_NOP));
  assign is_read    = (mode_reg == FLASH_MODE_W'(MODE_READ));
  assign is_prog    = (mode_reg == FLASH_MODE_W'(MODE_PROGRAM));
  assign is_erase   = (mode_reg == FLASH_MODE_W'(MODE_ERASE));
  assign is_illegal = !(is_nop || is_read || is_prog || is_erase);
  assign is_locked  = (is_prog || is_erase) && (32'(block_reg) < LOCK_BLOCKS);

  // One timer serves every pulse; load value picked by the operation
  nvm_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // State, response and latched-command registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= ST_IDLE;
      mode_reg  <= '0;
      block_reg <= '0;
      page_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      if (cmd_accept) begin
        mode_reg  <= cmd_mode;
        block_reg <= cmd_block;
        page_reg  <= cmd_page;
        wdata_reg <= cmd_wdata;
      end
    end
  end

`ifdef NVM_PROG_VERIFY_EN
  // Program attempts already retried for the current command
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      retry_reg <= '0;
    end else begin
      retry_reg <= retry_next;
    end
  end
`endif

  // Next-state, timer control and response capture
  always_comb begin
    state_next = state_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_en     = 1'b0;
`ifdef NVM_PROG_VERIFY_EN
    retry_next = retry_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next = ST_CHECK;
          rdata_next = '0;
          err_next   = 1'b0;
`ifdef NVM_PROG_VERIFY_EN
          retry_next = '0;
`endif
        end
      end
      ST_CHECK: begin
        if (is_nop) begin
          state_next = ST_RESP;
        end else if (is_illegal || is_locked) begin
          err_next   = 1'b1;
          state_next = ST_RESP;
        end else begin
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        tmr_load   = 1'b1;
        tmr_val    = is_read ? LD_READ : (is_prog ? LD_PROG : LD_ERASE);
        state_next = ST_PULSE;
      end
      ST_PULSE: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          if (is_read) begin
            rdata_next = flash_rdata;
          end
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
`ifdef NVM_PROG_VERIFY_EN
        if (is_prog) begin
          tmr_load   = 1'b1;
          tmr_val    = LD_READ;
          state_next = ST_VERIFY;
        end else begin
          state_next = ST_RESP;
        end
`else
        state_next = ST_RESP;
`endif
      end
`ifdef NVM_PROG_VERIFY_EN
      ST_VERIFY: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          if (flash_rdata == wdata_reg) begin
            state_next = ST_RESP;
          end else if (retry_reg < RETRY_W'(MAX_RETRY)) begin
            retry_next = retry_reg + 1'b1;
            state_next = ST_SETUP;
          end else begin
            err_next   = 1'b1;
            state_next = ST_RESP;
          end
        end
      end
`endif
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset drops them at once
  assign flash_re    = ((state_reg == ST_PULSE) && is_read)
`ifdef NVM_PROG_VERIFY_EN
                     || (state_reg == ST_VERIFY)
`endif
                     ;
  assign flash_we    = (state_reg == ST_PULSE) && is_prog;
  assign flash_erase = (state_reg == ST_PULSE) && is_erase;

  assign busy        = (state_reg != ST_IDLE);
  assign cmd_ready   = (state_reg == ST_IDLE);
  assign rsp_valid   = (state_reg == ST_RESP);
  assign rsp_rdata   = rdata_reg;
  assign rsp_err     = err_reg;
  assign flash_addr  = busy ? {block_reg, page_reg} : '0;
  assign flash_wdata = busy ? wdata_reg : '0;

endmodule

// File: tb/tb_nvm_flash_seq.sv
// tb_nvm_flash_seq: table of directed commands plus random commands checked
// against a reference model of the sequencer's observable behaviour.
module tb_nvm_flash_seq;

  localparam int WORD_W      = 32;
  localparam int BLOCK_W     = 10;
  localparam int PAGE_W      = 6;
  localparam int MODE_W      = 4;
  localparam int T_READ      = 2;
  localparam int T_PROG      = 8;
  localparam int T_ERASE     = 64;
  localparam int LOCK_BLOCKS = 1;
  localparam int MAX_RETRY   = 3;
  localparam int BUDGET      = 600;

  logic                      clk;
  logic                      n_rst;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [MODE_W-1:0]         cmd_mode;
  logic [BLOCK_W-1:0]        cmd_block;
  logic [PAGE_W-1:0]         cmd_page;
  logic [WORD_W-1:0]         cmd_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [WORD_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [BLOCK_W+PAGE_W-1:0] flash_addr;
  logic [WORD_W-1:0]         flash_wdata;
  logic [WORD_W-1:0]         flash_rdata;
  logic                      flash_re;
  logic                      flash_we;
  logic                      flash_erase;
  logic                      busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [MODE_W-1:0]  mode;
    logic [BLOCK_W-1:0] block;
    logic [PAGE_W-1:0]  page;
    logic [WORD_W-1:0]  wdata;
    logic [WORD_W-1:0]  rdata;
    int                 mism;
    int                 delay;
    bit                 early;
    bit                 offer;
    int                 e_lat;
    int                 e_re;
    int                 e_we;
    int                 e_er;
    int                 e_wep;
    bit                 e_err;
    logic [WORD_W-1:0]  e_rdata;
  } vec_t;

  typedef struct {
    int                lat;
    int                re;
    int                we;
    int                er;
    int                wep;
    int                addr_bad;
    int                wdata_bad;
    int                stab_bad;
    int                onehot_bad;
    int                post_bad;
    int                timeout;
    bit                err;
    logic [WORD_W-1:0] rdata;
  } obs_t;

  nvm_flash_seq #(
    .WORD_W       (WORD_W),
    .BLOCK_W      (BLOCK_W),
    .PAGE_W       (PAGE_W),
    .FLASH_MODE_W (MODE_W),
    .T_READ       (T_READ),
    .T_PROG       (T_PROG),
    .T_ERASE      (T_ERASE),
    .LOCK_BLOCKS  (LOCK_BLOCKS),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_block   (cmd_block),
    .cmd_page    (cmd_page),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .flash_addr  (flash_addr),
    .flash_wdata (flash_wdata),
    .flash_rdata (flash_rdata),
    .flash_re    (flash_re),
    .flash_we    (flash_we),
    .flash_erase (flash_erase),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int mode, input int block, input int page,
                              input logic [WORD_W-1:0] wdata, input logic [WORD_W-1:0] rdata,
                              input int mism, input int delay, input bit early, input bit offer,
                              input int e_lat, input int e_re, input int e_we, input int e_er,
                              input int e_wep, input bit e_err, input logic [WORD_W-1:0] e_rdata);
    vec_t v;
    v.mode = MODE_W'(mode);   v.block = BLOCK_W'(block); v.page = PAGE_W'(page);
    v.wdata = wdata;          v.rdata = rdata;           v.mism = mism;
    v.delay = delay;          v.early = early;           v.offer = offer;
    v.e_lat = e_lat;          v.e_re = e_re;             v.e_we = e_we;
    v.e_er = e_er;            v.e_wep = e_wep;           v.e_err = e_err;
    v.e_rdata = e_rdata;
    return v;
  endfunction

  // Reference model: what a command should produce, from the command's rules
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   t;
    int   a;
    bit   is_wr;
    bit   bad;
    r = v;
    is_wr = (v.mode == 2) || (v.mode == 3);
    bad = (v.mode > 3) || (is_wr && (int'(v.block) < LOCK_BLOCKS));
    r.e_re = 0; r.e_we = 0; r.e_er = 0; r.e_wep = 0;
    r.e_rdata = '0;
    r.e_err = bad;
    if ((v.mode == 0) || bad) begin
      r.e_lat = 2;
    end else begin
      t = (v.mode == 1) ? T_READ : ((v.mode == 2) ? T_PROG : T_ERASE);
      r.e_lat = 4 + t;
      if (v.mode == 1) begin
        r.e_re = t;
        r.e_rdata = v.rdata;
      end else if (v.mode == 2) begin
        r.e_we = t;
        r.e_wep = 1;
      end else begin
        r.e_er = t;
      end
`ifdef NVM_PROG_VERIFY_EN
      if (v.mode == 2) begin
        a = ((v.mism > MAX_RETRY) ? MAX_RETRY : v.mism) + 1;
        r.e_we  = a * T_PROG;
        r.e_wep = a;
        r.e_re  = a * T_READ;
        r.e_lat = 2 + a * (2 + T_PROG + T_READ);
        r.e_err = (v.mism > MAX_RETRY);
      end
`else
      a = 0;
`endif
    end
    return r;
  endfunction

  // Drive one command from a negedge, watch it to completion, end on a negedge in IDLE
  task automatic run_txn(input vec_t v, output obs_t o);
    bit seen;
    bit done;
    int held;
    bit prev_we;
    o = '{default: '0};
    seen = 0; done = 0; held = 0; prev_we = 0;
    check("cmd_ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_mode  = v.mode;
    cmd_block = v.block;
    cmd_page  = v.page;
    cmd_wdata = v.wdata;
    flash_rdata = (v.mode == 2) ? v.wdata : v.rdata;
    rsp_ready = v.early;
    for (int k = 1; k <= BUDGET && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Scramble command inputs after acceptance; they must be ignored
        cmd_valid = 1'b0;
        cmd_mode  = MODE_W'($urandom_range(0, 15));
        cmd_block = BLOCK_W'($urandom);
        cmd_page  = PAGE_W'($urandom);
        cmd_wdata = $urandom;
      end
      if (flash_re)    o.re++;
      if (flash_we)    o.we++;
      if (flash_erase) o.er++;
      if (flash_we && !prev_we) o.wep++;
      prev_we = flash_we;
      if ((int'(flash_re) + int'(flash_we) + int'(flash_erase)) > 1) o.onehot_bad++;
      if ((flash_re || flash_we || flash_erase) && (flash_addr != {v.block, v.page})) o.addr_bad++;
      if (flash_we && (flash_wdata != v.wdata)) o.wdata_bad++;
      if (v.mode == 2) begin
        flash_rdata = ((o.wep >= 1) && (o.wep <= v.mism)) ? ~v.wdata : v.wdata;
      end
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1; o.lat = k; o.err = rsp_err; o.rdata = rsp_rdata;
        end else if ((rsp_err !== o.err) || (rsp_rdata !== o.rdata)) begin
          o.stab_bad++;
        end
        if (cmd_ready) o.stab_bad++;
        if (held >= v.delay) begin
          rsp_ready = 1'b1;
          done = 1;
        end else begin
          held++;
          rsp_ready = 1'b0;
          if (v.offer) begin
            cmd_valid = 1'b1;
            cmd_mode  = '0;
          end
        end
      end
    end
    if (!done) o.timeout = 1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    if (rsp_valid || !cmd_ready || busy || (flash_addr != '0)) o.post_bad = 1;
  endtask

  task automatic do_txn(input int idx, input vec_t e);
    obs_t o;
    run_txn(e, o);
    $display("txn %0d: mode=%0d block=%0d page=%0d lat=%0d err=%0d rdata=%08h re=%0d we=%0d erase=%0d",
             idx, e.mode, e.block, e.page, o.lat, o.err, o.rdata, o.re, o.we, o.er);
    check("timeout",      o.timeout,    0);
    check("latency",      o.lat,        e.e_lat);
    check("rsp_err",      o.err,        e.e_err);
    check("rsp_rdata",    o.rdata,      e.e_rdata);
    check("re_cycles",    o.re,         e.e_re);
    check("we_cycles",    o.we,         e.e_we);
    check("erase_cycles", o.er,         e.e_er);
    check("we_pulses",    o.wep,        e.e_wep);
    check("addr_bad",     o.addr_bad,   0);
    check("wdata_bad",    o.wdata_bad,  0);
    check("onehot_bad",   o.onehot_bad, 0);
    check("rsp_stable",   o.stab_bad,   0);
    check("post_idle",    o.post_bad,   0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    cmd_valid = 0; cmd_mode = '0; cmd_block = '0; cmd_page = '0; cmd_wdata = '0;
    rsp_ready = 0; flash_rdata = '0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready",  cmd_ready,  1);
    check("rst_busy",       busy,       0);
    check("rst_rsp_valid",  rsp_valid,  0);
    check("rst_rsp_err",    rsp_err,    0);
    check("rst_rsp_rdata",  rsp_rdata,  0);
    check("rst_flash_addr", flash_addr, 0);
    check("rst_strobes",    {flash_re, flash_we, flash_erase}, 0);
    check("rst_wdata",      flash_wdata, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // mode, block, page, wdata, rdata, mism, delay, early, offer | lat, re, we, er, wep, err, rdata
    tbl.push_back(mk(1, 5, 3, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0,  6, 2, 0, 0, 0, 0, 32'hDEADBEEF));
`ifdef NVM_PROG_VERIFY_EN
    tbl.push_back(mk(2, 1, 0, 32'h12345678, 32'h0, 0, 0, 0, 0, 14, 2, 8, 0, 1, 0, 32'h0));
`else
    tbl.push_back(mk(2, 1, 0, 32'h12345678, 32'h0, 0, 0, 0, 0, 12, 0, 8, 0, 1, 0, 32'h0));
`endif
    tbl.push_back(mk(3, 0, 9, 32'h0, 32'h0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(7, 4, 2, 32'h0, 32'h0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 9, 1, 32'h0, 32'h0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 7, 10, 32'h0, 32'hCAFEF00D, 0, 5, 0, 1, 6, 2, 0, 0, 0, 0, 32'hCAFEF00D));
    tbl.push_back(mk(2, 0, 4, 32'hA5A5A5A5, 32'h0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 1, 32'h0, 32'h0BADC0DE, 0, 0, 1, 0, 6, 2, 0, 0, 0, 0, 32'h0BADC0DE));
    tbl.push_back(mk(3, 3, 0, 32'h0, 32'h0, 0, 0, 0, 0, 68, 0, 0, 64, 0, 0, 32'h0));
    tbl.push_back(mk(9, 2, 2, 32'h0, 32'h0, 0, 2, 0, 0,  2, 0, 0, 0, 0, 1, 32'h0));
`ifdef NVM_PROG_VERIFY_EN
    tbl.push_back(mk(2, 2, 5, 32'h0F0F1234, 32'h0, 2, 0, 0, 0, 38, 6, 24, 0, 3, 0, 32'h0));
    tbl.push_back(mk(2, 6, 8, 32'h55AA00FF, 32'h0, 99, 0, 0, 0, 50, 8, 32, 0, 4, 1, 32'h0));
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      do_txn(i, tbl[i]);
    end

    // Reset during the 30th erase pulse cycle: strobe and response must vanish at once
    cmd_valid = 1'b1; cmd_mode = 4'd3; cmd_block = 10'd2; cmd_page = 6'd7; cmd_wdata = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (31) @(negedge clk);
    check("erase_before_rst", flash_erase, 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("erase_at_rst", flash_erase, 0);
    check("busy_at_rst",  busy,        0);
    check("ready_at_rst", cmd_ready,   1);
    check("addr_at_rst",  flash_addr,  0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);
    check("busy_after_rst",  busy,      0);
    check("rsp_after_rst",   rsp_valid, 0);
    $display("txn reset: erase interrupted, sequencer idle after release");

    // Random commands against the reference model
    for (int i = 0; i < 30; i++) begin
      v = mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      v.mode  = MODE_W'($urandom_range(0, 7));
      v.block = ($urandom_range(0, 3) == 0) ? '0 : BLOCK_W'($urandom);
      v.page  = PAGE_W'($urandom);
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.mism  = $urandom_range(0, 5);
      v.early = ($urandom_range(0, 3) == 0);
      v.delay = v.early ? 0 : $urandom_range(0, 3);
      v.offer = ($urandom_range(0, 1) == 1);
      do_txn(100 + i, model(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
